// File: rtl/pdm_array_scan_demux.sv
// PDM microphone array scanner: walks the external column mux, captures one row slice
// per column after a settle time, and publishes the remapped frame with a valid strobe.
module pdm_array_scan_demux #(
    parameter int NUM_ROWS   = 5,
    parameter int NUM_COLS   = 8,
    parameter int SEL_WIDTH  = $clog2(NUM_COLS),
    parameter int STEP_WIDTH = 3,
    parameter int COL_GROUP  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         lr_sel,
    input  logic                         both_edges,
    input  logic                         pulse_lr,
    input  logic                         pdm_clk,
    input  logic [NUM_ROWS-1:0]          pdm_inp,
    input  logic [STEP_WIDTH-1:0]        cnt_step,
    input  logic                         ovr_clr,
    output logic [SEL_WIDTH-1:0]         adapter_sel_ff,
    output logic [NUM_COLS*NUM_ROWS-1:0] adapter_out_ff,
    output logic                         out_valid_ff,
    output logic                         out_side_ff,
    output logic                         overrun_ff
);
    localparam logic [SEL_WIDTH-1:0] LAST_COL = SEL_WIDTH'(NUM_COLS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                              state_q, state_d;
    logic [SEL_WIDTH-1:0]                col_cnt_q;
    logic [STEP_WIDTH-1:0]               step_q, step_rld_q;
    logic                                side_q, tl_q, pclk_q;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0]   shadow_q;
    logic [NUM_COLS*NUM_ROWS-1:0]        out_q, remap;
    logic                                valid_q, side_out_q, ovr_q;
    logic                                tl, trig;
    logic                                start, abort, capture, count, publish, ovr_set;

    // Both-edge mode qualifies on the window alone and adds pdm_clk toggles as events.
    assign tl   = pulse_lr & (both_edges | (lr_sel ? pdm_clk : ~pdm_clk));
    assign trig = enable & ((tl & ~tl_q) | (both_edges & pulse_lr & (pdm_clk ^ pclk_q)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else if (trig) begin
            state_d = SCAN;
        end else begin
            case (state_q)
                SCAN:    if (step_q == '0 && col_cnt_q == '0) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        start   = trig;
        abort   = !enable && state_q != IDLE;
        capture = enable && !trig && state_q == SCAN && step_q == '0;
        count   = enable && !trig && state_q == SCAN && step_q != '0;
        publish = enable && !trig && state_q == DONE;
        ovr_set = trig && state_q != IDLE;
    end

    // Column c lands at the mirrored position inside its COL_GROUP-wide block.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_remap
        localparam int M = (c / COL_GROUP) * COL_GROUP + (COL_GROUP - 1 - c % COL_GROUP);
        assign remap[M*NUM_ROWS +: NUM_ROWS] = shadow_q[c];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt_q  <= LAST_COL;
            step_q     <= '0;
            step_rld_q <= '0;
            side_q     <= 1'b0;
            tl_q       <= 1'b0;
            pclk_q     <= 1'b0;
            shadow_q   <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            side_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            tl_q    <= tl;
            pclk_q  <= pdm_clk;
            valid_q <= publish;
            if (start) begin
                col_cnt_q  <= LAST_COL;
                step_q     <= cnt_step;
                step_rld_q <= cnt_step;
                side_q     <= pdm_clk;
            end else if (abort || publish) begin
                col_cnt_q <= LAST_COL;
            end else if (capture) begin
                shadow_q[col_cnt_q] <= pdm_inp;
                step_q              <= step_rld_q;
                if (col_cnt_q != '0) col_cnt_q <= col_cnt_q - 1'b1;
            end else if (count) begin
                step_q <= step_q - 1'b1;
            end
            if (publish) begin
                out_q      <= remap;
                side_out_q <= side_q;
            end
            if (ovr_set)      ovr_q <= 1'b1;
            else if (ovr_clr) ovr_q <= 1'b0;
        end
    end

    assign adapter_sel_ff = col_cnt_q;
    assign adapter_out_ff = out_q;
    assign out_valid_ff   = valid_q;
    assign out_side_ff    = side_out_q;
    assign overrun_ff     = ovr_q;
endmodule
